lct_match_sequencer: RTL and testbench

Sequences ALCT/CLCT pairing for the LCT quality encoder. It latches the first-arriving ALCT or CLCT and opens a programmable match window for its partner. It then drives the combinational quality encoder from registered inputs, captures the 4-bit quality, and presents the result to the downstream LCT builder on a valid/ready handshake. It sits between the ALCT receiver / CLCT pattern finder and the MPC frame builder.

---
 rtl/lct_match_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_lct_match_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lct_match_sequencer.sv
// ALCT/CLCT pairing sequencer: latches the first arrival, waits a programmable
// window for its partner, drives the quality encoder and hands the result downstream.
module lct_match_sequencer #(
  parameter int unsigned MATCH_WIN = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alct_vld,
  input  logic [2:0] alct_nlyr,
  input  logic       alct_acc,
  input  logic       clct_vld,
  input  logic [2:0] clct_nlyr,
  input  logic [3:0] clct_pat,
  output logic       enc_a,
  output logic       enc_c,
  output logic       enc_a4,
  output logic       enc_c4,
  output logic       enc_cpat,
  output logic       enc_acc,
  output logic [3:0] enc_p,
  input  logic [3:0] enc_q,
  output logic       lct_vld,
  output logic [3:0] lct_q,
  output logic [3:0] lct_pat,
  input  logic       lct_rdy,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_C = 3'd1,
    WAIT_A = 3'd2,
    EVAL   = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam logic [3:0] TMAX = 4'(MATCH_WIN - 1);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;

  logic       a_vld_q, a_vld_d;
  logic [2:0] a_nlyr_q, a_nlyr_d;
  logic       a_acc_q, a_acc_d;
  logic       c_vld_q, c_vld_d;
  logic [2:0] c_nlyr_q, c_nlyr_d;
  logic [3:0] c_pat_q, c_pat_d;

  logic [3:0] q_q, q_d;
  logic [3:0] pat_q, pat_d;
  logic [7:0] drop_q, drop_d;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    a_vld_d  = a_vld_q;
    a_nlyr_d = a_nlyr_q;
    a_acc_d  = a_acc_q;
    c_vld_d  = c_vld_q;
    c_nlyr_d = c_nlyr_q;
    c_pat_d  = c_pat_q;
    q_d      = q_q;
    pat_d    = pat_q;
    drop_inc = '0;

    unique case (state_q)
      IDLE: begin
        if (alct_vld) begin
          a_vld_d  = 1'b1;
          a_nlyr_d = alct_nlyr;
          a_acc_d  = alct_acc;
        end
        if (clct_vld) begin
          c_vld_d  = 1'b1;
          c_nlyr_d = clct_nlyr;
          c_pat_d  = clct_pat;
        end
        timer_d = '0;
        if (alct_vld && clct_vld) begin
          state_d = EVAL;
        end else if (alct_vld) begin
          state_d = WAIT_C;
        end else if (clct_vld) begin
          state_d = WAIT_A;
        end
      end

      WAIT_C: begin
        // A second ALCT never replaces the one already latched.
        drop_inc = {1'b0, alct_vld};
        if (clct_vld) begin
          c_vld_d  = 1'b1;
          c_nlyr_d = clct_nlyr;
          c_pat_d  = clct_pat;
          state_d  = EVAL;
        end else if (timer_q == TMAX) begin
          state_d = EVAL;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end

      WAIT_A: begin
        drop_inc = {1'b0, clct_vld};
        if (alct_vld) begin
          a_vld_d  = 1'b1;
          a_nlyr_d = alct_nlyr;
          a_acc_d  = alct_acc;
          state_d  = EVAL;
        end else if (timer_q == TMAX) begin
          state_d = EVAL;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end

      EVAL: begin
        drop_inc = {1'b0, alct_vld} + {1'b0, clct_vld};
        q_d      = enc_q;
        pat_d    = enc_p;
        state_d  = OUT;
      end

      OUT: begin
        drop_inc = {1'b0, alct_vld} + {1'b0, clct_vld};
        if (lct_rdy) begin
          state_d  = IDLE;
          a_vld_d  = 1'b0;
          a_nlyr_d = '0;
          a_acc_d  = 1'b0;
          c_vld_d  = 1'b0;
          c_nlyr_d = '0;
          c_pat_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = drop_sum[8] ? '1 : drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      a_vld_q  <= 1'b0;
      a_nlyr_q <= '0;
      a_acc_q  <= 1'b0;
      c_vld_q  <= 1'b0;
      c_nlyr_q <= '0;
      c_pat_q  <= '0;
      q_q      <= '0;
      pat_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      a_vld_q  <= a_vld_d;
      a_nlyr_q <= a_nlyr_d;
      a_acc_q  <= a_acc_d;
      c_vld_q  <= c_vld_d;
      c_nlyr_q <= c_nlyr_d;
      c_pat_q  <= c_pat_d;
      q_q      <= q_d;
      pat_q    <= pat_d;
      drop_q   <= drop_d;
    end
  end

  // Encoder inputs come only from the latches so enc_q has a full cycle to settle.
  always_comb begin
    enc_a    = a_vld_q;
    enc_c    = c_vld_q;
    enc_a4   = a_vld_q && (a_nlyr_q >= 3'd4);
    enc_c4   = c_vld_q && (c_nlyr_q >= 3'd4);
    enc_p    = c_vld_q ? c_pat_q : '0;
    enc_cpat = c_vld_q && (c_pat_q >= 4'd2) && (c_pat_q <= 4'd10);
    enc_acc  = a_vld_q && a_acc_q;
  end

  assign lct_vld  = (state_q == OUT);
  assign lct_q    = q_q;
  assign lct_pat  = pat_q;
  assign busy     = (state_q != IDLE);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_lct_match_sequencer.sv
// Scoreboard bench for lct_match_sequencer with a simple behavioural quality encoder.
module tb_lct_match_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       alct_vld, alct_acc, clct_vld, lct_rdy;
  logic [2:0] alct_nlyr, clct_nlyr;
  logic [3:0] clct_pat;
  logic       enc_a, enc_c, enc_a4, enc_c4, enc_cpat, enc_acc;
  logic [3:0] enc_p, enc_q;
  logic       lct_vld, busy;
  logic [3:0] lct_q, lct_pat;
  logic [7:0] drop_cnt;

  lct_match_sequencer #(.MATCH_WIN(3)) dut (
    .clock(clock), .reset(reset),
    .alct_vld(alct_vld), .alct_nlyr(alct_nlyr), .alct_acc(alct_acc),
    .clct_vld(clct_vld), .clct_nlyr(clct_nlyr), .clct_pat(clct_pat),
    .enc_a(enc_a), .enc_c(enc_c), .enc_a4(enc_a4), .enc_c4(enc_c4),
    .enc_cpat(enc_cpat), .enc_acc(enc_acc), .enc_p(enc_p), .enc_q(enc_q),
    .lct_vld(lct_vld), .lct_q(lct_q), .lct_pat(lct_pat), .lct_rdy(lct_rdy),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Stand-in quality encoder: 15 full match, 11 good match, 3 weak match, 1 ALCT only, 2 CLCT only.
  always_comb begin
    if (enc_a && enc_c)
      enc_q = (enc_a4 && enc_c4 && enc_cpat) ? 4'd15 : (enc_a4 && enc_c4) ? 4'd11 : 4'd3;
    else if (enc_a) enc_q = 4'd1;
    else if (enc_c) enc_q = 4'd2;
    else            enc_q = 4'd0;
  end

  typedef struct {
    logic [3:0]  q;
    logic [3:0]  pat;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  logic        have_cur = 1'b0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned t0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] q, input logic [3:0] pat, input int unsigned c);
    exp_t e;
    e.q = q; e.pat = pat; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic drive_a(input logic [2:0] n, input logic acc);
    alct_vld = 1'b1; alct_nlyr = n; alct_acc = acc;
  endtask

  task automatic drive_c(input logic [2:0] n, input logic [3:0] p);
    clct_vld = 1'b1; clct_nlyr = n; clct_pat = p;
  endtask

  task automatic idle_in();
    alct_vld = 1'b0; alct_nlyr = '0; alct_acc = 1'b0;
    clct_vld = 1'b0; clct_nlyr = '0; clct_pat = '0;
  endtask

  // Monitor: pops an expectation when lct_vld rises, checks every cycle it is held.
  always @(negedge clock) begin
    if (reset) begin
      have_cur = 1'b0;
    end else if (lct_vld) begin
      if (!have_cur) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_lct: lct_q=%0d lct_pat=%0d with empty scoreboard (cycle %0d)",
                   lct_q, lct_pat, cyc);
        end else begin
          cur = sbq.pop_front();
          have_cur = 1'b1;
          chk("lct_vld_cycle", cyc, cur.cyc);
        end
      end
      if (have_cur) begin
        chk("lct_q", lct_q, cur.q);
        chk("lct_pat", lct_pat, cur.pat);
        if (lct_rdy) have_cur = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; lct_rdy = 1'b1;
    idle_in();
    repeat (3) tick();
    chk("rst_lct_vld", lct_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lct_q", lct_q, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_enc_a", enc_a, 0);
    chk("rst_enc_p", enc_p, 0);
    reset = 1'b0;
    tick();

    // Simultaneous arrival
    t0 = cyc;
    drive_a(3'd5, 1'b0); drive_c(3'd6, 4'd10);
    push(4'd15, 4'd10, t0 + 2);
    tick(); idle_in();
    chk("sim_busy", busy, 1);
    repeat (3) tick();
    chk("sim_drop", drop_cnt, 0);
    chk("sim_idle", busy, 0);

    // ALCT first, CLCT two cycles later
    t0 = cyc;
    drive_a(3'd4, 1'b0);
    tick(); idle_in();
    tick(); drive_c(3'd3, 4'd1);
    push(4'd3, 4'd1, t0 + 4);
    tick(); idle_in();
    repeat (3) tick();

    // ALCT alone times out
    t0 = cyc;
    drive_a(3'd4, 1'b1);
    push(4'd1, 4'd0, t0 + 5);
    chk("to_enc_c", enc_c, 0);
    tick(); idle_in();
    chk("to_enc_a", enc_a, 1);
    chk("to_enc_a4", enc_a4, 1);
    chk("to_enc_acc", enc_acc, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("to_enc_c", enc_c, 0);
      tick();
    end
    chk("to_enc_c", enc_c, 0);
    chk("to_vld", lct_vld, 1);
    repeat (2) tick();

    // Backpressure with drops while held in OUT
    lct_rdy = 1'b0;
    t0 = cyc;
    drive_a(3'd4, 1'b0); drive_c(3'd4, 4'd12);
    push(4'd11, 4'd12, t0 + 2);
    tick(); idle_in();
    tick();
    tick(); drive_a(3'd7, 1'b1);
    tick(); idle_in();
    tick(); drive_c(3'd7, 4'd3);
    tick(); idle_in();
    chk("bp_vld_held", lct_vld, 1);
    chk("bp_drop", drop_cnt, 2);
    tick();
    lct_rdy = 1'b1;
    tick();
    chk("bp_vld_drop", lct_vld, 0);
    chk("bp_busy", busy, 0);
    chk("bp_drop2", drop_cnt, 2);
    tick();

    // ALCT in WAIT_C coinciding with the partner CLCT is dropped, not latched
    t0 = cyc;
    drive_a(3'd5, 1'b0);
    tick(); drive_a(3'd1, 1'b0); drive_c(3'd4, 4'd2);
    push(4'd15, 4'd2, t0 + 3);
    tick(); idle_in();
    repeat (3) tick();
    chk("coin_drop", drop_cnt, 3);

    // Partner at the last window cycle still matches
    t0 = cyc;
    drive_c(3'd5, 4'd9);
    tick(); idle_in();
    tick(); tick();
    drive_a(3'd4, 1'b0);
    push(4'd15, 4'd9, t0 + 5);
    tick(); idle_in();
    repeat (3) tick();
    chk("lastwin_drop", drop_cnt, 3);

    // Partner one cycle past the window lands in EVAL and is dropped
    t0 = cyc;
    drive_c(3'd5, 4'd7);
    push(4'd2, 4'd7, t0 + 5);
    tick(); idle_in();
    repeat (3) tick();
    drive_a(3'd4, 1'b0);
    tick(); idle_in();
    repeat (3) tick();
    chk("late_drop", drop_cnt, 4);

    // Reset in the middle of a window
    drive_a(3'd4, 1'b0);
    tick(); idle_in();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", lct_vld, 0);
    chk("mid_rst_enc_a", enc_a, 0);
    chk("mid_rst_lct_q", lct_q, 0);
    chk("mid_rst_lct_pat", lct_pat, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    tick();
    t0 = cyc;
    drive_c(3'd3, 4'd4);
    push(4'd2, 4'd4, t0 + 5);
    tick(); idle_in();
    chk("c_enc_c", enc_c, 1);
    chk("c_enc_a", enc_a, 0);
    chk("c_enc_c4", enc_c4, 0);
    chk("c_enc_cpat", enc_cpat, 1);
    chk("c_enc_p", enc_p, 4);
    repeat (6) tick();

    // Saturation of drop_cnt with 300 discarded arrivals
    lct_rdy = 1'b0;
    t0 = cyc;
    drive_a(3'd2, 1'b0); drive_c(3'd2, 4'd3);
    push(4'd3, 4'd3, t0 + 2);
    tick(); idle_in();
    tick();
    for (int unsigned i = 0; i < 127; i++) begin
      drive_a(3'd1, 1'b0); drive_c(3'd1, 4'd1);
      tick();
    end
    idle_in();
    chk("sat_254", drop_cnt, 254);
    drive_a(3'd1, 1'b0); drive_c(3'd1, 4'd1);
    tick(); idle_in();
    chk("sat_255", drop_cnt, 255);
    for (int unsigned i = 0; i < 22; i++) begin
      drive_a(3'd1, 1'b0); drive_c(3'd1, 4'd1);
      tick();
    end
    idle_in();
    chk("sat_hold", drop_cnt, 255);
    lct_rdy = 1'b1;
    tick();
    tick();
    chk("sat_idle", busy, 0);

    for (int unsigned i = 0; i < 20 && (sbq.size() != 0 || have_cur); i++) tick();
    chk("sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
